ram_port_master: RTL and testbench
==================================

Name: ram_port_master

Overview:
- Request-side controller that drives one port of the team's single-port byte-enabled RAM. It sits between a valid/ready client and the RAM pins.
- Converts client read and write requests into registered RAM port cycles.
- Tracks the RAM's fixed read latency of 1 or 2 cycles.
- Returns read data in order through a response FIFO that honours backpressure, so no read data is ever dropped.

Parameters:
- DATA_WIDTH, 8: RAM word width; multiple of 8.
- ADDR_WIDTH, 8: RAM address width.
- RD_LATENCY, 1: RAM read latency in cycles; 1 or 2. Must equal the attached RAM: 1 = no output register, 2 = output register present.
- RSP_DEPTH, 4: response FIFO depth; power of 2, at least RD_LATENCY+1.
- BYTE_VALID_WIDTH, localparam DATA_WIDTH/8.

Ports:
- clk_i  in  1  single clock; the RAM shares it.
- arst_n_i  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_wr_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_WIDTH  request address.
- req_data_i  in  DATA_WIDTH  write data.
- req_byte_valid_i  in  BYTE_VALID_WIDTH  write byte enables.
- rsp_valid_o  out  1  read response valid.
- rsp_ready_i  in  1  read response ready.
- rsp_data_o  out  DATA_WIDTH  read response data.
- ram_wr_en_o  out  1  to RAM wr_en_i.
- ram_data_o  out  DATA_WIDTH  to RAM data_i.
- ram_byte_valid_o  out  BYTE_VALID_WIDTH  to RAM byte_valid_i.
- ram_addr_o  out  ADDR_WIDTH  to RAM addr_i.
- ram_data_i  in  DATA_WIDTH  from RAM data_o.

Behaviour:
- Reset: one clock, clk_i; reset is asynchronous and active-low (arst_n_i). While asserted, all outputs are 0 and the FIFO, credit counter and latency pipeline are cleared. Deassertion is synchronised externally.
- Reset mid-operation: in-flight reads are discarded and no response is produced for them.
- Acceptance: a request is accepted on a rising edge with req_valid_i && req_ready_o.
- req_ready_o is 1 when credit < RSP_DEPTH, where credit = reads issued but not yet captured + FIFO occupancy. req_ready_o does not depend on req_wr_i.
- Accept at edge E0: at E0 the block registers ram_addr_o, ram_data_o, ram_byte_valid_o and ram_wr_en_o = req_wr_i. The RAM samples them at E1.
- Cycles with no accept:
  - ram_wr_en_o = 0 and ram_byte_valid_o = 0.
  - ram_addr_o and ram_data_o hold their last value.
- Writes consume no credit and produce no response.
- Read tracking: each accepted read sets a tag bit in a shift register of length RD_LATENCY+1.
  - The RAM word is captured into the FIFO at edge E1+RD_LATENCY.
  - Minimum accept-to-rsp_valid_o latency is RD_LATENCY+1 cycles: 2 with RD_LATENCY=1, 3 with RD_LATENCY=2.
- Throughput: one request per cycle, sustained, while rsp_ready_i = 1.
- Ordering: responses are returned strictly in request order. A read to an address accepted after a write to the same address returns the new data; the RAM commits the write one edge before sampling the read.
- Response FIFO:
  - rsp_valid_o = FIFO not empty; rsp_data_o = FIFO head.
  - Pop on rsp_valid_o && rsp_ready_i.
  - rsp_data_o is stable while rsp_valid_o=1 and rsp_ready_i=0.
- Credit:
  - +1 on read accept, −1 on pop.
  - Read accept and pop on the same edge leave credit unchanged.
  - Credit never exceeds RSP_DEPTH, so the FIFO cannot overflow.
- Boundaries:
  - Credit = RSP_DEPTH: req_ready_o = 0 and requests are stalled.
  - A pop in a cycle makes req_ready_o = 1 in the next cycle. There is no combinational path from rsp_ready_i to req_ready_o.
  - FIFO pointers wrap modulo RSP_DEPTH.
  - A write with req_byte_valid_i = 0 is legal: ram_wr_en_o pulses and memory is unchanged.

Optional Feature:
- Macro: RAM_PORT_MASTER_STATS_EN.
- Defined:
  - Adds outputs rd_cnt_o[31:0], wr_cnt_o[31:0] and stall_cnt_o[31:0], all reset to 0.
  - rd_cnt_o / wr_cnt_o increment on each accepted read / write.
  - stall_cnt_o increments on each cycle with req_valid_i && !req_ready_o.
  - All counters saturate at 0xFFFFFFFF.
- Undefined: these ports and the counter logic do not exist.

Test Plan:
- Reset: assert arst_n_i asynchronously mid-burst of 3 reads -> all outputs 0 immediately, credit 0, no stale response after release.
- Write then read (RD_LATENCY=1): write addr 0x10 data 0xA5 byte_valid 1, then read 0x10 back-to-back -> rsp_data_o = 0xA5 exactly 2 cycles after the read accept.
- Byte enables (DATA_WIDTH=32): write 0x11223344 to addr 3, then write 0xFFFFFFFF with byte_valid 0b0101, then read addr 3 -> 0x11FF33FF.
- Backpressure (RSP_DEPTH=4): rsp_ready_i=0 and 6 reads of addrs 0..5 -> req_ready_o drops after the 4th accept. Release rsp_ready_i -> data for 0..5 returned in order, none lost.
- RD_LATENCY=2 streaming: 16 consecutive reads with rsp_ready_i=1 -> 16 responses, first one 3 cycles after the first accept, then one per cycle.
- With RAM_PORT_MASTER_STATS_EN defined: run the backpressure scenario -> rd_cnt_o=6, wr_cnt_o=0, stall_cnt_o equals the number of cycles with req_valid_i=1 and req_ready_o=0.

Source files
------------

// File: rtl/ram_port_master.sv
// Request-side controller for one port of a single-port byte-enabled RAM with in-order read return.
// Optional RAM_PORT_MASTER_STATS_EN adds saturating read/write/stall counters.
module ram_port_master #(
   parameter  int unsigned DATA_WIDTH       = 8,
   parameter  int unsigned ADDR_WIDTH       = 8,
   parameter  int unsigned RD_LATENCY       = 1,
   parameter  int unsigned RSP_DEPTH        = 4,
   localparam int unsigned BYTE_VALID_WIDTH = DATA_WIDTH / 8
) (
   input  logic                        clk_i,
   input  logic                        arst_n_i,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  logic                        req_wr_i,
   input  logic [ADDR_WIDTH-1:0]       req_addr_i,
   input  logic [DATA_WIDTH-1:0]       req_data_i,
   input  logic [BYTE_VALID_WIDTH-1:0] req_byte_valid_i,
   output logic                        rsp_valid_o,
   input  logic                        rsp_ready_i,
   output logic [DATA_WIDTH-1:0]       rsp_data_o,
   output logic                        ram_wr_en_o,
   output logic [DATA_WIDTH-1:0]       ram_data_o,
   output logic [BYTE_VALID_WIDTH-1:0] ram_byte_valid_o,
   output logic [ADDR_WIDTH-1:0]       ram_addr_o,
`ifdef RAM_PORT_MASTER_STATS_EN
   output logic [31:0]                 rd_cnt_o,
   output logic [31:0]                 wr_cnt_o,
   output logic [31:0]                 stall_cnt_o,
`endif
   input  logic [DATA_WIDTH-1:0]       ram_data_i
);

   localparam int unsigned PTR_W   = $clog2(RSP_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned TAG_LEN = RD_LATENCY + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

   logic                  req_ready_q;
   logic                  accept;
   logic                  rd_accept;
   logic                  push;
   logic                  pop;
   logic [CNT_W-1:0]      credit_q;
   logic [CNT_W-1:0]      credit_d;
   logic [TAG_LEN-1:0]    tag_q;
   logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      count_d;

   assign accept      = req_valid_i & req_ready_q;
   assign rd_accept   = accept & ~req_wr_i;
   assign push        = tag_q[RD_LATENCY];
   assign pop         = rsp_valid_o & rsp_ready_i;
   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = (count_q != '0);
   assign rsp_data_o  = fifo_mem[rd_ptr_q];

   // Credit covers reads still in the RAM pipeline plus FIFO entries, so a push always has room.
   always_comb begin
      credit_d = credit_q;
      if (rd_accept && !pop) begin
         credit_d = credit_q + CNT_W'(1);
      end else if (!rd_accept && pop) begin
         credit_d = credit_q - CNT_W'(1);
      end
   end

   always_comb begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // Ready is registered from next-state credit: a pop frees a slot for the following cycle.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         credit_q    <= '0;
         req_ready_q <= 1'b0;
         tag_q       <= '0;
      end else begin
         credit_q    <= credit_d;
         req_ready_q <= (credit_d < DEPTH_C);
         tag_q       <= {tag_q[TAG_LEN-2:0], rd_accept};
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         ram_wr_en_o      <= 1'b0;
         ram_byte_valid_o <= '0;
         ram_addr_o       <= '0;
         ram_data_o       <= '0;
      end else if (accept) begin
         ram_wr_en_o      <= req_wr_i;
         ram_byte_valid_o <= req_byte_valid_i;
         ram_addr_o       <= req_addr_i;
         ram_data_o       <= req_data_i;
      end else begin
         ram_wr_en_o      <= 1'b0;
         ram_byte_valid_o <= '0;
      end
   end

   // Pointers are PTR_W bits wide, so they wrap modulo RSP_DEPTH on their own.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(RSP_DEPTH); i++) begin
            fifo_mem[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         if (push) begin
            fifo_mem[wr_ptr_q] <= ram_data_i;
            wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

`ifdef RAM_PORT_MASTER_STATS_EN
   logic wr_accept;
   logic stall;

   assign wr_accept = accept & req_wr_i;
   assign stall     = req_valid_i & ~req_ready_q;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         rd_cnt_o    <= '0;
         wr_cnt_o    <= '0;
         stall_cnt_o <= '0;
      end else begin
         if (rd_accept && (rd_cnt_o != '1)) begin
            rd_cnt_o <= rd_cnt_o + 32'd1;
         end
         if (wr_accept && (wr_cnt_o != '1)) begin
            wr_cnt_o <= wr_cnt_o + 32'd1;
         end
         if (stall && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ram_port_master.sv
// Directed bench: two instances (read latency 1 and 2) each attached to a behavioural RAM.
// Counter checks are compiled in when RAM_PORT_MASTER_STATS_EN is defined.
module tb_ram_port_master;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } rsp_t;

   logic clk;
   logic arst_n;
   int   cyc_cnt;
   int   n_checks;
   int   n_errors;
   rsp_t qa[$];
   rsp_t qb[$];

   // Instance A: latency 1, depth 4
   logic        a_valid, a_ready, a_wr, a_rsp_valid, a_rsp_ready, a_ram_wr_en;
   logic [7:0]  a_addr, a_ram_addr, a_addr_r;
   logic [31:0] a_wdata, a_rsp_data, a_ram_wdata, a_ram_rdata;
   logic [3:0]  a_be, a_ram_be;
   logic [31:0] mem_a [256];

   // Instance B: latency 2, depth 8
   logic        b_valid, b_ready, b_wr, b_rsp_valid, b_rsp_ready, b_ram_wr_en;
   logic [7:0]  b_addr, b_ram_addr, b_addr_r;
   logic [31:0] b_wdata, b_rsp_data, b_ram_wdata, b_ram_rdata, b_dout;
   logic [3:0]  b_be, b_ram_be;
   logic [31:0] mem_b [256];

`ifdef RAM_PORT_MASTER_STATS_EN
   logic [31:0] a_rd_cnt, a_wr_cnt, a_stall_cnt;
   logic [31:0] b_rd_cnt, b_wr_cnt, b_stall_cnt;
`endif

   ram_port_master #(
      .DATA_WIDTH(32), .ADDR_WIDTH(8), .RD_LATENCY(1), .RSP_DEPTH(4)
   ) u_dut_a (
      .clk_i            (clk),
      .arst_n_i         (arst_n),
      .req_valid_i      (a_valid),
      .req_ready_o      (a_ready),
      .req_wr_i         (a_wr),
      .req_addr_i       (a_addr),
      .req_data_i       (a_wdata),
      .req_byte_valid_i (a_be),
      .rsp_valid_o      (a_rsp_valid),
      .rsp_ready_i      (a_rsp_ready),
      .rsp_data_o       (a_rsp_data),
      .ram_wr_en_o      (a_ram_wr_en),
      .ram_data_o       (a_ram_wdata),
      .ram_byte_valid_o (a_ram_be),
      .ram_addr_o       (a_ram_addr),
`ifdef RAM_PORT_MASTER_STATS_EN
      .rd_cnt_o         (a_rd_cnt),
      .wr_cnt_o         (a_wr_cnt),
      .stall_cnt_o      (a_stall_cnt),
`endif
      .ram_data_i       (a_ram_rdata)
   );

   ram_port_master #(
      .DATA_WIDTH(32), .ADDR_WIDTH(8), .RD_LATENCY(2), .RSP_DEPTH(8)
   ) u_dut_b (
      .clk_i            (clk),
      .arst_n_i         (arst_n),
      .req_valid_i      (b_valid),
      .req_ready_o      (b_ready),
      .req_wr_i         (b_wr),
      .req_addr_i       (b_addr),
      .req_data_i       (b_wdata),
      .req_byte_valid_i (b_be),
      .rsp_valid_o      (b_rsp_valid),
      .rsp_ready_i      (b_rsp_ready),
      .rsp_data_o       (b_rsp_data),
      .ram_wr_en_o      (b_ram_wr_en),
      .ram_data_o       (b_ram_wdata),
      .ram_byte_valid_o (b_ram_be),
      .ram_addr_o       (b_ram_addr),
`ifdef RAM_PORT_MASTER_STATS_EN
      .rd_cnt_o         (b_rd_cnt),
      .wr_cnt_o         (b_wr_cnt),
      .stall_cnt_o      (b_stall_cnt),
`endif
      .ram_data_i       (b_ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Behavioural RAMs; contents reload to a known pattern whenever reset is held.
   always @(posedge clk) begin
      if (!arst_n) begin
         for (int i = 0; i < 256; i++) mem_a[i] <= 32'hCAFE_0000 + i;
      end else if (a_ram_wr_en) begin
         for (int k = 0; k < 4; k++)
            if (a_ram_be[k]) mem_a[a_ram_addr][8*k +: 8] <= a_ram_wdata[8*k +: 8];
      end
      a_addr_r <= a_ram_addr;
   end
   assign a_ram_rdata = mem_a[a_addr_r];

   always @(posedge clk) begin
      if (!arst_n) begin
         for (int i = 0; i < 256; i++) mem_b[i] <= 32'hBEEF_0000 + i;
      end else if (b_ram_wr_en) begin
         for (int k = 0; k < 4; k++)
            if (b_ram_be[k]) mem_b[b_ram_addr][8*k +: 8] <= b_ram_wdata[8*k +: 8];
      end
      b_addr_r <= b_ram_addr;
      b_dout   <= mem_b[b_addr_r];
   end
   assign b_ram_rdata = b_dout;

   // Each negedge with valid && ready is exactly one pop on the following edge.
   always @(negedge clk) begin
      if (a_rsp_valid && a_rsp_ready) qa.push_back('{a_rsp_data, cyc_cnt});
      if (b_rsp_valid && b_rsp_ready) qb.push_back('{b_rsp_data, cyc_cnt});
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                         input logic [3:0] be, output int acc);
      int n;
      n = 0;
      a_valid = 1'b1; a_wr = wr; a_addr = addr; a_wdata = data; a_be = be;
      while (!a_ready && n < 50) begin
         cyc();
         n++;
      end
      if (n >= 50) check_eq("a_ready_timeout", a_ready, 1);
      cyc();
      acc = cyc_cnt;
      a_valid = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] addr, output int acc);
      int n;
      n = 0;
      b_valid = 1'b1; b_wr = 1'b0; b_addr = addr; b_wdata = '0; b_be = '0;
      while (!b_ready && n < 50) begin
         cyc();
         n++;
      end
      if (n >= 50) check_eq("b_ready_timeout", b_ready, 1);
      cyc();
      acc = cyc_cnt;
      b_valid = 1'b0;
   endtask

   task automatic wait_qa(input int n);
      int k;
      k = 0;
      while (qa.size() < n && k < 100) begin
         cyc();
         k++;
      end
      check_eq("a_rsp_count", qa.size(), n);
   endtask

   task automatic wait_qb(input int n);
      int k;
      k = 0;
      while (qb.size() < n && k < 200) begin
         cyc();
         k++;
      end
      check_eq("b_rsp_count", qb.size(), n);
   endtask

   initial begin
      int acc;
      int acc0;
      arst_n = 1'b0;
      a_valid = 0; a_wr = 0; a_addr = 0; a_wdata = 0; a_be = 0; a_rsp_ready = 0;
      b_valid = 0; b_wr = 0; b_addr = 0; b_wdata = 0; b_be = 0; b_rsp_ready = 0;
      #1;
      check_eq("init_ready", a_ready, 0);
      check_eq("init_rsp_valid", a_rsp_valid, 0);
      check_eq("init_b_ready", b_ready, 0);
      repeat (3) @(posedge clk);
      @(negedge clk) arst_n = 1'b1;
      cyc();
      check_eq("ready_after_reset", a_ready, 1);

      // Reset during a burst of three reads
      send_a(0, 8'd0, 0, 0, acc);
      send_a(0, 8'd1, 0, 0, acc);
      send_a(0, 8'd2, 0, 0, acc);
      check_eq("burst_rsp_valid", a_rsp_valid, 1);
      check_eq("burst_rsp_data", a_rsp_data, 32'hCAFE_0000);
      #2 arst_n = 1'b0;
      #1;
      check_eq("rst_ready", a_ready, 0);
      check_eq("rst_rsp_valid", a_rsp_valid, 0);
      check_eq("rst_rsp_data", a_rsp_data, 0);
      check_eq("rst_wr_en", a_ram_wr_en, 0);
      check_eq("rst_addr", a_ram_addr, 0);
      check_eq("rst_be", a_ram_be, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) begin
         arst_n = 1'b1;
         a_rsp_ready = 1'b1;
      end
      repeat (6) cyc();
      check_eq("rst_no_stale_rsp", qa.size(), 0);
      check_eq("rst_rsp_valid_after", a_rsp_valid, 0);
      check_eq("rst_ready_after", a_ready, 1);

      // Backpressure: four reads fill the credit, two more stall until responses drain
      a_rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send_a(0, 8'(i), 0, 0, acc);
         check_eq("bp_ready", a_ready, (i < 3) ? 1 : 0);
      end
      a_valid = 1'b1; a_wr = 1'b0; a_addr = 8'd4;
      repeat (3) begin
         cyc();
         check_eq("bp_stalled", a_ready, 0);
      end
      a_rsp_ready = 1'b1;
      send_a(0, 8'd4, 0, 0, acc);
      send_a(0, 8'd5, 0, 0, acc);
      wait_qa(6);
      for (int i = 0; i < 6; i++) begin
         if (i < qa.size()) check_eq("bp_order", qa[i].data, 32'hCAFE_0000 + i);
      end
`ifdef RAM_PORT_MASTER_STATS_EN
      check_eq("stats_rd", a_rd_cnt, 6);
      check_eq("stats_wr", a_wr_cnt, 0);
      check_eq("stats_stall", a_stall_cnt, 4);
`endif
      qa.delete();

      // Write then back-to-back read of the same address
      send_a(1, 8'h10, 32'h0000_00A5, 4'b0001, acc);
      check_eq("wr_pin_en", a_ram_wr_en, 1);
      check_eq("wr_pin_addr", a_ram_addr, 8'h10);
      check_eq("wr_pin_data", a_ram_wdata, 32'h0000_00A5);
      check_eq("wr_pin_be", a_ram_be, 4'b0001);
      send_a(0, 8'h10, 0, 0, acc);
      check_eq("rd_pin_en", a_ram_wr_en, 0);
      cyc();
      check_eq("idle_addr_hold", a_ram_addr, 8'h10);
      wait_qa(1);
      if (qa.size() > 0) begin
         check_eq("wr_rd_data", qa[0].data, 32'hCAFE_00A5);
         check_eq("wr_rd_latency", qa[0].cyc - acc, 2);
      end
      qa.delete();

      // Byte enables, including an all-zero enable write
      send_a(1, 8'd3, 32'h1122_3344, 4'b1111, acc);
      send_a(1, 8'd3, 32'hFFFF_FFFF, 4'b0101, acc);
      send_a(0, 8'd3, 0, 0, acc);
      wait_qa(1);
      if (qa.size() > 0) check_eq("be_merge", qa[0].data, 32'h11FF_33FF);
      qa.delete();
      send_a(1, 8'd3, 32'hDEAD_BEEF, 4'b0000, acc);
      check_eq("be0_wr_en", a_ram_wr_en, 1);
      check_eq("be0_pin_be", a_ram_be, 0);
      cyc();
      check_eq("idle_wr_en", a_ram_wr_en, 0);
      check_eq("idle_data_hold", a_ram_wdata, 32'hDEAD_BEEF);
      send_a(0, 8'd3, 0, 0, acc);
      wait_qa(1);
      if (qa.size() > 0) check_eq("be0_unchanged", qa[0].data, 32'h11FF_33FF);
      qa.delete();

      // Latency-2 instance streaming 16 reads
      b_rsp_ready = 1'b1;
      acc0 = 0;
      for (int i = 0; i < 16; i++) begin
         send_b(8'(i), acc);
         if (i == 0) acc0 = acc;
         check_eq("b_accept_cycle", acc - acc0, i);
      end
      wait_qb(16);
      for (int i = 0; i < 16; i++) begin
         if (i < qb.size()) begin
            check_eq("b_stream_data", qb[i].data, 32'hBEEF_0000 + i);
            check_eq("b_stream_cycle", qb[i].cyc - acc0, 3 + i);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
